// File: rtl/nco_phase_acc.sv
// nco_phase_acc: NCO phase accumulator driving the wave-table address.
// Accumulates a double-buffered tuning word on each sample tick, adds a
// phase offset, and registers the truncated A-bit address with valid/wrap.
// Optional build macro: NCO_PHASE_DITHER_EN adds LFSR dither below the
// address LSB before truncation.
module nco_phase_acc #(
  parameter int unsigned W = 32,
  parameter int unsigned A = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] ftw_in,
  input  logic         ftw_load,
  input  logic [A-1:0] off_in,
  input  logic         off_load,
  input  logic         sync_clr,
  output logic [A-1:0] address,
  output logic         valid,
  output logic         wrap,
  output logic [W-1:0] ftw_active
);

  logic [W-1:0] acc;
  logic [W-1:0] shadow;
  logic         pending;
  logic [A-1:0] off_reg;

  logic [W:0]   sum;
  logic         carry;
  logic [W-1:0] acc_next;
  logic [A-1:0] phase_top;
  logic [A-1:0] addr_next;

`ifdef NCO_PHASE_DITHER_EN
  localparam int unsigned DW = W - A;
  localparam logic [W-1:0] DMASK = (W'(1) << DW) - W'(1);

  logic [15:0]  lfsr;
  logic         lfsr_fb;
  logic [W-1:0] dither;
  logic [W-1:0] dithered;

  // Dither value: low W-A bits of the LFSR, confined below the address LSB
  always_comb begin
    lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    dither   = W'(lfsr) & DMASK;
    dithered = acc_next + dither;
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per sample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (en) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end
`endif

  // Next accumulator value, carry-out and offset-adjusted address
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, ftw_active};
    carry    = sum[W];
    acc_next = sync_clr ? '0 : sum[W-1:0];
`ifdef NCO_PHASE_DITHER_EN
    phase_top = dithered[W-1:W-A];
`else
    phase_top = acc_next[W-1:W-A];
`endif
    addr_next = phase_top + off_reg;
  end

  // Accumulator: advances on tick, sync_clr zeroes it with or without a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end else if (sync_clr) begin
      acc <= '0;
    end
  end

  // Registered outputs: address updates only on a tick; valid/wrap are pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      valid <= en;
      wrap  <= en & ~sync_clr & carry;
      if (en) begin
        address <= addr_next;
      end
    end
  end

  // FTW double buffer: the commit edge still adds the old word; a load on
  // the commit edge refills the shadow and keeps pending set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      pending    <= 1'b0;
      ftw_active <= '0;
    end else begin
      if (en && pending) begin
        ftw_active <= shadow;
      end
      if (ftw_load) begin
        shadow <= ftw_in;
      end
      pending <= ftw_load | (pending & ~en);
    end
  end

  // Phase offset register, captured immediately regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_reg <= '0;
    end else if (off_load) begin
      off_reg <= off_in;
    end
  end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Self-checking bench for nco_phase_acc (default build, W=32, A=8).
module tb_nco_phase_acc;

  localparam longint unsigned TWO_W = 64'h1_0000_0000;
  localparam longint unsigned LSB   = 64'h100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] ftw_in;
  logic        ftw_load;
  logic [7:0]  off_in;
  logic        off_load;
  logic        sync_clr;
  logic [7:0]  address;
  logic        valid;
  logic        wrap;
  logic [31:0] ftw_active;

  int checks = 0;
  int errors = 0;

  nco_phase_acc #(.W(32), .A(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ftw_in(ftw_in), .ftw_load(ftw_load),
    .off_in(off_in), .off_load(off_load), .sync_clr(sync_clr),
    .address(address), .valid(valid), .wrap(wrap), .ftw_active(ftw_active)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers, modulo arithmetic
  longint unsigned m_acc, m_act, m_shadow, m_off, m_addr;
  bit m_pend, m_valid, m_wrap;

  typedef struct packed {
    logic        en;
    logic        ld;
    logic [31:0] ftw;
    logic        ol;
    logic [7:0]  off;
    logic        sc;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic        e_wrap;
    logic [31:0] e_act;
  } vec_t;

  vec_t tbl[41];

  function automatic vec_t mk(input logic e, input logic l, input logic [31:0] f,
                              input logic o, input logic [7:0] ov, input logic s,
                              input logic [7:0] ea, input logic ev, input logic ew,
                              input logic [31:0] eact);
    vec_t v;
    v.en = e; v.ld = l; v.ftw = f; v.ol = o; v.off = ov; v.sc = s;
    v.e_addr = ea; v.e_valid = ev; v.e_wrap = ew; v.e_act = eact;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_act = 0; m_shadow = 0; m_off = 0; m_addr = 0;
    m_pend = 0; m_valid = 0; m_wrap = 0;
  endtask

  // Apply the spec's per-edge rules to the model using the current inputs
  task automatic model_edge();
    longint unsigned s, nacc;
    if (en) begin
      s       = m_acc + m_act;
      nacc    = sync_clr ? 0 : s % TWO_W;
      m_wrap  = !sync_clr && (s >= TWO_W);
      m_addr  = ((nacc / LSB) + m_off) % 256;
      m_valid = 1;
      if (m_pend) begin
        m_act  = m_shadow;
        m_pend = 0;
      end
    end else begin
      nacc    = sync_clr ? 0 : m_acc;
      m_valid = 0;
      m_wrap  = 0;
    end
    m_acc = nacc;
    if (ftw_load) begin
      m_shadow = ftw_in;
      m_pend   = 1;
    end
    if (off_load) m_off = off_in;
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, ".address"}, 64'(address), 64'(m_addr));
    chk({tag, ".valid"}, 64'(valid), 64'(m_valid));
    chk({tag, ".wrap"}, 64'(wrap), 64'(m_wrap));
    chk({tag, ".ftw_active"}, 64'(ftw_active), 64'(m_act));
  endtask

  task automatic drive(input logic e, input logic l, input logic [31:0] f,
                       input logic o, input logic [7:0] ov, input logic s,
                       input string tag);
    @(negedge clk);
    en = e; ftw_load = l; ftw_in = f; off_load = o; off_in = ov; sync_clr = s;
    @(posedge clk);
    model_edge();
    #1;
    model_cmp(tag);
  endtask

  initial begin
    rst = 1'b1; en = 0; ftw_load = 0; ftw_in = '0; off_load = 0; off_in = '0; sync_clr = 0;
    model_reset();

    // Directed vectors: hand-derived expected outputs
    tbl[0]  = mk(1,1,32'h0100_0000,0,0,0, 8'd0,  1,0,32'h0000_0000);
    tbl[1]  = mk(1,0,0,0,0,0,              8'd0,  1,0,32'h0100_0000);
    tbl[2]  = mk(1,0,0,0,0,0,              8'd1,  1,0,32'h0100_0000);
    tbl[3]  = mk(1,0,0,0,0,0,              8'd2,  1,0,32'h0100_0000);
    tbl[4]  = mk(1,0,0,0,0,0,              8'd3,  1,0,32'h0100_0000);
    tbl[5]  = mk(0,1,32'h0200_0000,0,0,0, 8'd3,  0,0,32'h0100_0000);
    tbl[6]  = mk(1,0,0,0,0,0,              8'd4,  1,0,32'h0200_0000);
    tbl[7]  = mk(1,0,0,0,0,0,              8'd6,  1,0,32'h0200_0000);
    tbl[8]  = mk(1,0,0,0,0,0,              8'd8,  1,0,32'h0200_0000);
    tbl[9]  = mk(0,1,32'h0100_0000,0,0,0, 8'd8,  0,0,32'h0200_0000);
    tbl[10] = mk(1,0,0,0,0,0,              8'd10, 1,0,32'h0100_0000);
    tbl[11] = mk(0,0,0,1,8'd64,0,          8'd10, 0,0,32'h0100_0000);
    tbl[12] = mk(1,0,0,0,0,0,              8'd75, 1,0,32'h0100_0000);
    tbl[13] = mk(1,0,0,1,8'd192,0,         8'd76, 1,0,32'h0100_0000);
    tbl[14] = mk(1,0,0,0,0,0,              8'd205,1,0,32'h0100_0000);
    tbl[15] = mk(0,1,32'h6400_0000,0,0,0, 8'd205,0,0,32'h0100_0000);
    tbl[16] = mk(1,0,0,0,0,1,              8'd192,1,0,32'h6400_0000);
    tbl[17] = mk(1,0,0,0,0,0,              8'd36, 1,0,32'h6400_0000);
    tbl[18] = mk(0,0,0,0,0,0,              8'd36, 0,0,32'h6400_0000);
    tbl[19] = mk(0,0,0,0,0,0,              8'd36, 0,0,32'h6400_0000);
    tbl[20] = mk(1,0,0,0,0,0,              8'd136,1,0,32'h6400_0000);
    tbl[21] = mk(1,0,0,0,0,0,              8'd236,1,1,32'h6400_0000);
    tbl[22] = mk(0,0,0,1,8'd5,0,           8'd236,0,0,32'h6400_0000);
    tbl[23] = mk(1,0,0,0,0,1,              8'd5,  1,0,32'h6400_0000);
    tbl[24] = mk(1,0,0,0,0,0,              8'd105,1,0,32'h6400_0000);
    tbl[25] = mk(0,1,32'h0100_0000,0,0,0, 8'd105,0,0,32'h6400_0000);
    tbl[26] = mk(1,0,0,0,0,0,              8'd205,1,0,32'h0100_0000);
    tbl[27] = mk(0,0,0,0,0,1,              8'd205,0,0,32'h0100_0000);
    tbl[28] = mk(1,0,0,0,0,0,              8'd6,  1,0,32'h0100_0000);
    tbl[29] = mk(0,1,32'hFF00_0000,0,0,0, 8'd6,  0,0,32'h0100_0000);
    tbl[30] = mk(1,0,0,0,0,0,              8'd7,  1,0,32'hFF00_0000);
    tbl[31] = mk(1,0,0,0,0,0,              8'd6,  1,1,32'hFF00_0000);
    tbl[32] = mk(1,0,0,0,0,1,              8'd5,  1,0,32'hFF00_0000);
    tbl[33] = mk(0,1,32'h0100_0000,0,0,0, 8'd5,  0,0,32'hFF00_0000);
    tbl[34] = mk(0,1,32'h0300_0000,0,0,0, 8'd5,  0,0,32'hFF00_0000);
    tbl[35] = mk(1,0,0,0,0,0,              8'd4,  1,0,32'h0300_0000);
    tbl[36] = mk(1,0,0,0,0,0,              8'd7,  1,1,32'h0300_0000);
    tbl[37] = mk(0,1,32'h0100_0000,0,0,0, 8'd7,  0,0,32'h0300_0000);
    tbl[38] = mk(1,1,32'h0200_0000,0,0,0, 8'd10, 1,0,32'h0100_0000);
    tbl[39] = mk(1,0,0,0,0,0,              8'd11, 1,0,32'h0200_0000);
    tbl[40] = mk(1,0,0,0,0,0,              8'd13, 1,0,32'h0200_0000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.address", 64'(address), 64'd0);
    chk("reset.valid", 64'(valid), 64'd0);
    chk("reset.wrap", 64'(wrap), 64'd0);
    chk("reset.ftw_active", 64'(ftw_active), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Startup rows, then a full 256-tick revolution to see the wrap pulse
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].ftw, tbl[i].ol, tbl[i].off, tbl[i].sc, $sformatf("row%0d", i));
      chk($sformatf("row%0d.addr_hand", i), 64'(address), 64'(tbl[i].e_addr));
      chk($sformatf("row%0d.act_hand", i), 64'(ftw_active), 64'(tbl[i].e_act));
    end
    for (int k = 4; k < 260; k++) begin
      drive(1, 0, '0, 0, '0, 0, "rev");
      chk("rev.addr_hand", 64'(address), 64'(k % 256));
      chk("rev.wrap_hand", 64'(wrap), 64'((k % 256) == 0));
    end
    for (int i = 5; i < 41; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].ftw, tbl[i].ol, tbl[i].off, tbl[i].sc, $sformatf("row%0d", i));
      chk($sformatf("row%0d.addr_hand", i), 64'(address), 64'(tbl[i].e_addr));
      chk($sformatf("row%0d.valid_hand", i), 64'(valid), 64'(tbl[i].e_valid));
      chk($sformatf("row%0d.wrap_hand", i), 64'(wrap), 64'(tbl[i].e_wrap));
      chk($sformatf("row%0d.act_hand", i), 64'(ftw_active), 64'(tbl[i].e_act));
    end

    // Asynchronous reset mid-cycle with an FTW pending
    drive(0, 1, 32'h0500_0000, 0, '0, 0, "prerst");
    #2;
    rst = 1'b1; en = 0; ftw_load = 0; off_load = 0; sync_clr = 0;
    #1;
    chk("async_rst.address", 64'(address), 64'd0);
    chk("async_rst.valid", 64'(valid), 64'd0);
    chk("async_rst.ftw_active", 64'(ftw_active), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, '0, 0, '0, 0, "postrst");
      chk("postrst.addr_hand", 64'(address), 64'd0);
      chk("postrst.act_hand", 64'(ftw_active), 64'd0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom,
            ($urandom % 8) == 0, 8'($urandom), ($urandom % 24) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
